// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the fetch stage and the controller that drives PC_s.
package pc_fetch_unit_pkg;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_JR  = 2'b01;
  localparam logic [1:0] PC_BR  = 2'b10;
  localparam logic [1:0] PC_J   = 2'b11;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_EXEC  = 2'b01,
    ST_ERR   = 2'b10
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit_next_pc_calc.sv
// Combinational next-PC selection: sequential, register-indirect, PC-relative branch, or region jump.
module pc_fetch_unit_next_pc_calc
  import pc_fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] instr,
  input  logic [31:0] rs_data,
  input  logic [1:0]  PC_s,
  output logic [31:0] next_pc,
  output logic        misalign
);

  logic        [31:0] seq_pc;
  logic signed [15:0] br_imm;
  logic signed [31:0] br_off;

  assign seq_pc = pc + 32'd4;
  assign br_imm = instr[15:0];
  // Word offset: sign-extend the 16-bit immediate, then scale by 4.
  assign br_off = 32'(br_imm) <<< 2;

  always_comb begin
    next_pc  = seq_pc;
    misalign = 1'b0;
    unique case (PC_s)
      PC_SEQ: next_pc = seq_pc;
      PC_JR: begin
        next_pc  = {rs_data[31:2], 2'b00};
        misalign = (rs_data[1:0] != 2'b00);
      end
      PC_BR:   next_pc = seq_pc + $unsigned(br_off);
      PC_J:    next_pc = {seq_pc[31:28], instr[25:0], 2'b00};
      default: next_pc = seq_pc;
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch: FETCH over a ready handshake, one EXEC strobe, then advance.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned IMEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  PC_s,
  input  logic [31:0] rs_data,
  input  logic        hold,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        exec_en,
  output logic        misalign_err,
  output logic        fetch_err
);

  fetch_state_t state, state_nxt;
  logic [31:0]  next_pc;
  logic         misalign;
  logic [15:0]  cnt;
  logic         timeout_hit;

  pc_fetch_unit_next_pc_calc u_next_pc (
    .pc       (pc),
    .instr    (instr[25:0]),
    .rs_data  (rs_data),
    .PC_s     (PC_s),
    .next_pc  (next_pc),
    .misalign (misalign)
  );

  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;

  // Counter is 16 bits wide, so IMEM_TIMEOUT is meaningful up to 65535.
  assign timeout_hit = (IMEM_TIMEOUT != 0) && (cnt == 16'(IMEM_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_FETCH: begin
        if (imem_ready)       state_nxt = ST_EXEC;
        else if (timeout_hit) state_nxt = ST_ERR;
      end
      ST_EXEC: if (!hold) state_nxt = ST_FETCH;
      ST_ERR:  state_nxt = ST_ERR;
      default: state_nxt = ST_ERR;
    endcase
  end

  // Request is gated by rst_n so it drops the moment reset asserts.
  always_comb begin
    imem_req = rst_n && (state == ST_FETCH);
    exec_en  = (state == ST_EXEC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      instr        <= NOP_INSTR;
      cnt          <= '0;
      misalign_err <= 1'b0;
      fetch_err    <= 1'b0;
    end else begin
      unique case (state)
        ST_FETCH: begin
          if (imem_ready) begin
            instr <= imem_rdata;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 16'd1;
            if (timeout_hit) fetch_err <= 1'b1;
          end
        end
        ST_EXEC: begin
          if (!hold) begin
            pc <= next_pc;
            if (misalign) misalign_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
